mdio_responder: RTL



---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_edge_sync.sv | 29 ++
 rtl/mdio_responder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO responder: FSM states, opcodes,
// register addresses and reset constants.
package mdio_pkg;

    typedef enum logic [3:0] {
        S_PRE   = 4'd0,
        S_ST    = 4'd1,
        S_OP    = 4'd2,
        S_PHYAD = 4'd3,
        S_REGAD = 4'd4,
        S_TA    = 4'd5,
        S_RDATA = 4'd6,
        S_WDATA = 4'd7,
        S_SKIP  = 4'd8
    } mdio_state_t;

    localparam logic [1:0]  OP_READ    = 2'b10;
    localparam logic [1:0]  OP_WRITE   = 2'b01;

    localparam logic [4:0]  REG_BMCR   = 5'd0;
    localparam logic [4:0]  REG_BMSR   = 5'd1;
    localparam logic [4:0]  REG_ID1    = 5'd2;
    localparam logic [4:0]  REG_ID2    = 5'd3;

    localparam logic [15:0] BMCR_RESET = 16'h3100;
    localparam logic [15:0] BMSR_BASE  = 16'h7809;

    // Link status is mirrored into BMSR bits 5 and 2.
    function automatic logic [15:0] bmsr_value(input logic link_up);
        return BMSR_BASE | {10'd0, link_up, 2'd0, link_up, 2'd0};
    endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Two-flop synchronisers for the asynchronous MDC/MDIO pins plus a one-cycle
// pulse on each synchronised MDC rising edge.
module mdio_edge_sync (
    input  logic msoc_clk,
    input  logic rstn,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic mdc_rise,
    output logic mdio_sync
);

    logic [2:0] mdc_sync_r;
    logic [1:0] mdio_sync_r;

    // Synchroniser chains; the third MDC stage holds the previous sample.
    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            mdc_sync_r  <= 3'b000;
            mdio_sync_r <= 2'b00;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[1:0], i_mdc};
            mdio_sync_r <= {mdio_sync_r[0], i_mdio};
        end
    end

    assign mdc_rise  = mdc_sync_r[1] & ~mdc_sync_r[2];
    assign mdio_sync = mdio_sync_r[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target serving a small PHY register file.
// Optional MDIO_RESP_PREAMBLE_SUPPRESS_EN: accept a frame after a 1-bit preamble.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1560,
    parameter int unsigned PREAMBLE_MIN = 32
) (
    input  logic        msoc_clk,
    input  logic        rstn,
    input  logic        i_mdc,
    input  logic        i_mdio,
    output logic        o_mdio,
    output logic        oe_mdio,
    input  logic        i_link_up,
    output logic        o_loopback,
    output logic        o_power_down,
    output logic        o_wr_valid,
    output logic [4:0]  o_wr_addr,
    output logic [15:0] o_wr_data
);

    localparam logic [7:0] PRE_MAX = 8'(PREAMBLE_MIN);
`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    localparam logic [7:0] PRE_AFTER_FRAME = PRE_MAX - 8'd1;
`else
    localparam logic [7:0] PRE_AFTER_FRAME = 8'd0;
`endif

    logic        mdc_rise_s;
    logic        mdio_s;
    logic [15:0] shift_in_s;
    logic [15:0] rd_value_s;

    mdio_state_t state_r;
    logic [7:0]  pre_cnt_r;
    logic [4:0]  bit_cnt_r;
    logic [14:0] shift_r;
    logic        is_read_r;
    logic        foreign_r;
    logic [4:0]  regad_r;
    logic [15:0] rd_shift_r;
    logic [15:0] bmcr_r;
    logic [15:0] scratch_r [4];

    mdio_edge_sync u_sync (
        .msoc_clk  (msoc_clk),
        .rstn      (rstn),
        .i_mdc     (i_mdc),
        .i_mdio    (i_mdio),
        .mdc_rise  (mdc_rise_s),
        .mdio_sync (mdio_s)
    );

    assign shift_in_s   = {shift_r, mdio_s};
    assign o_loopback   = bmcr_r[14];
    assign o_power_down = bmcr_r[11];

    // Read mux addressed by the register field as it completes.
    always_comb begin
        rd_value_s = 16'h0000;
        case (shift_in_s[4:0])
            REG_BMCR:                   rd_value_s = bmcr_r;
            REG_BMSR:                   rd_value_s = bmsr_value(i_link_up);
            REG_ID1:                    rd_value_s = PHY_ID1;
            REG_ID2:                    rd_value_s = PHY_ID2;
            5'd4, 5'd5, 5'd6, 5'd7:     rd_value_s = scratch_r[shift_in_s[1:0]];
            default:                    rd_value_s = 16'h0000;
        endcase
    end

    // Frame FSM, pin drive and register file; everything steps on an MDC rise.
    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            state_r    <= S_PRE;
            pre_cnt_r  <= 8'd0;
            bit_cnt_r  <= 5'd0;
            shift_r    <= 15'd0;
            is_read_r  <= 1'b0;
            foreign_r  <= 1'b0;
            regad_r    <= 5'd0;
            rd_shift_r <= 16'h0000;
            bmcr_r     <= BMCR_RESET;
            for (int i = 0; i < 4; i++) scratch_r[i] <= 16'h0000;
            o_mdio     <= 1'b0;
            oe_mdio    <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= 5'd0;
            o_wr_data  <= 16'h0000;
        end else begin
            o_wr_valid <= 1'b0;
            if (mdc_rise_s) begin
                case (state_r)
                    S_PRE: begin
                        if (mdio_s) begin
                            if (pre_cnt_r != PRE_MAX) pre_cnt_r <= pre_cnt_r + 8'd1;
                        end else if (pre_cnt_r == PRE_MAX) begin
                            state_r <= S_ST;
                        end else begin
                            pre_cnt_r <= 8'd0;
                        end
                    end
                    S_ST: begin
                        bit_cnt_r <= 5'd0;
                        if (mdio_s) begin
                            state_r <= S_OP;
                        end else begin
                            state_r   <= S_PRE;
                            pre_cnt_r <= 8'd0;
                        end
                    end
                    S_OP: begin
                        shift_r <= shift_in_s[14:0];
                        if (bit_cnt_r == 5'd1) begin
                            bit_cnt_r <= 5'd0;
                            is_read_r <= (shift_in_s[1:0] == OP_READ);
                            if (shift_in_s[1:0] == OP_READ || shift_in_s[1:0] == OP_WRITE) begin
                                state_r <= S_PHYAD;
                            end else begin
                                state_r <= S_SKIP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_PHYAD: begin
                        shift_r <= shift_in_s[14:0];
                        if (bit_cnt_r == 5'd4) begin
                            bit_cnt_r <= 5'd0;
                            foreign_r <= (shift_in_s[4:0] != PHY_ADDR);
                            state_r   <= S_REGAD;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_REGAD: begin
                        shift_r <= shift_in_s[14:0];
                        if (bit_cnt_r == 5'd4) begin
                            bit_cnt_r  <= 5'd0;
                            regad_r    <= shift_in_s[4:0];
                            rd_shift_r <= rd_value_s;
                            state_r    <= foreign_r ? S_SKIP : S_TA;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_TA: begin
                        if (bit_cnt_r == 5'd0) begin
                            bit_cnt_r <= 5'd1;
                            if (is_read_r) begin
                                oe_mdio <= 1'b1;
                                o_mdio  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_r <= 5'd0;
                            if (is_read_r) begin
                                o_mdio     <= rd_shift_r[15];
                                rd_shift_r <= {rd_shift_r[14:0], 1'b0};
                                state_r    <= S_RDATA;
                            end else begin
                                state_r <= S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (bit_cnt_r == 5'd15) begin
                            oe_mdio   <= 1'b0;
                            o_mdio    <= 1'b0;
                            state_r   <= S_PRE;
                            pre_cnt_r <= PRE_AFTER_FRAME;
                        end else begin
                            o_mdio     <= rd_shift_r[15];
                            rd_shift_r <= {rd_shift_r[14:0], 1'b0};
                            bit_cnt_r  <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_WDATA: begin
                        shift_r <= shift_in_s[14:0];
                        if (bit_cnt_r == 5'd15) begin
                            o_wr_valid <= 1'b1;
                            o_wr_addr  <= regad_r;
                            o_wr_data  <= shift_in_s;
                            state_r    <= S_PRE;
                            pre_cnt_r  <= PRE_AFTER_FRAME;
                            // Read-only and unmapped addresses still pulse but store nothing.
                            case (regad_r)
                                REG_BMCR: begin
                                    if (shift_in_s[15]) begin
                                        bmcr_r <= BMCR_RESET;
                                        for (int i = 0; i < 4; i++) scratch_r[i] <= 16'h0000;
                                    end else begin
                                        bmcr_r <= {1'b0, shift_in_s[14:0]};
                                    end
                                end
                                5'd4, 5'd5, 5'd6, 5'd7: scratch_r[regad_r[1:0]] <= shift_in_s;
                                default: begin
                                end
                            endcase
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_SKIP: begin
                        if (bit_cnt_r == 5'd17) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_PRE;
                            pre_cnt_r <= 8'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    default: begin
                        state_r   <= S_PRE;
                        pre_cnt_r <= 8'd0;
                        oe_mdio   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
